// File: rtl/dmem_arbiter_pkg.sv
// dmem_arb_pkg
//   Shared definitions for the data-memory arbiter slice.
//   - arb_state_e       : arbiter FSM states (IDLE -> ACCESS -> RESP)
//   - PORT_CPU/PORT_DBG : requester index constants used as grant values
//   - DEFAULT_MEM_LIMIT : first illegal byte address of the data memory
package dmem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } arb_state_e;

  localparam int PORT_CPU = 0;
  localparam int PORT_DBG = 1;

  localparam int DEFAULT_MEM_LIMIT = 1024;

endpackage

// File: rtl/dmem_arbiter_if.sv
// dmem_arbiter_if
//   Bundles the two requester ports and the data-memory port of the arbiter.
//   Requester side : REQn/WEn/ADDRn/WDn in, ACKn/ERR/RDATA/BUSY out
//   Memory side    : MEM_ADDR/MEM_RW/MEM_WD out, MEM_RD in
//   slave  modport : seen by the arbiter
//   master modport : seen by the environment (requesters plus memory)
interface dmem_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);

  logic              REQ0;
  logic              REQ1;
  logic              WE0;
  logic              WE1;
  logic [ADDR_W-1:0] ADDR0;
  logic [ADDR_W-1:0] ADDR1;
  logic [DATA_W-1:0] WD0;
  logic [DATA_W-1:0] WD1;

  logic              ACK0;
  logic              ACK1;
  logic              ERR;
  logic [DATA_W-1:0] RDATA;
  logic              BUSY;

  logic [ADDR_W-1:0] MEM_ADDR;
  logic              MEM_RW;
  logic [DATA_W-1:0] MEM_WD;
  logic [DATA_W-1:0] MEM_RD;

  modport slave (
    input  REQ0, REQ1, WE0, WE1, ADDR0, ADDR1, WD0, WD1, MEM_RD,
    output ACK0, ACK1, ERR, RDATA, BUSY, MEM_ADDR, MEM_RW, MEM_WD
  );

  modport master (
    output REQ0, REQ1, WE0, WE1, ADDR0, ADDR1, WD0, WD1, MEM_RD,
    input  ACK0, ACK1, ERR, RDATA, BUSY, MEM_ADDR, MEM_RW, MEM_WD
  );

endinterface

// File: rtl/dmem_arbiter_rr_pick.sv
// dmem_rr_pick
//   Combinational two-way round-robin picker.
//   req[1:0] : request bits, bit n = port n
//   prio     : port favoured when both ports request
//   valid    : at least one request present
//   gnt      : index of the winning port (meaningful only when valid)
module dmem_rr_pick
  import dmem_arb_pkg::*;
(
  input  logic [1:0] req,
  input  logic       prio,
  output logic       valid,
  output logic       gnt
);

  // A lone requester always wins; prio only breaks a tie.
  always_comb begin
    valid = |req;
    gnt   = 1'(PORT_CPU);
    case (req)
      2'b01:   gnt = 1'(PORT_CPU);
      2'b10:   gnt = 1'(PORT_DBG);
      2'b11:   gnt = prio;
      default: gnt = 1'(PORT_CPU);
    endcase
  end

endmodule

// File: rtl/dmem_arbiter.sv
// dmem_arbiter
//   Shares the single-ported word data memory between the CPU load/store
//   unit (port 0) and the debug/DMA loader (port 1). One access at a time:
//   IDLE -> ACCESS -> RESP -> IDLE, one access every three cycles.
//   CLK : system clock, rising edge
//   RST : asynchronous active-high reset
//   bus : dmem_arbiter_if.slave
//         REQn/WEn/ADDRn/WDn  request, held until ACKn
//         ACKn                one-cycle completion pulse in RESP
//         ERR                 out-of-range or misaligned access, with ACKn
//         RDATA               read data captured at the end of ACCESS
//         BUSY                high in ACCESS and RESP
//         MEM_ADDR/RW/WD/RD   data memory port
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int MEM_LIMIT = DEFAULT_MEM_LIMIT
) (
  input logic           CLK,
  input logic           RST,
  dmem_arbiter_if.slave bus
);

  localparam logic [1:0] S_IDLE   = IDLE;
  localparam logic [1:0] S_ACCESS = ACCESS;
  localparam logic [1:0] S_RESP   = RESP;

  logic [1:0]        state;
  logic              prio;
  logic              gnt;
  logic              lat_we;
  logic              lat_err;
  logic [ADDR_W-1:0] lat_addr;
  logic [DATA_W-1:0] lat_wd;
  logic [DATA_W-1:0] rdata_q;

  logic              pick_valid;
  logic              pick_gnt;
  logic              win_we;
  logic              win_err;
  logic [ADDR_W-1:0] win_addr;
  logic [DATA_W-1:0] win_wd;

  dmem_rr_pick u_pick (
    .req   ({bus.REQ1, bus.REQ0}),
    .prio  (prio),
    .valid (pick_valid),
    .gnt   (pick_gnt)
  );

  // Winner's request fields, and its error status decided once at latch time.
  always_comb begin
    win_we   = pick_gnt ? bus.WE1   : bus.WE0;
    win_addr = pick_gnt ? bus.ADDR1 : bus.ADDR0;
    win_wd   = pick_gnt ? bus.WD1   : bus.WD0;
    win_err  = (win_addr >= ADDR_W'(MEM_LIMIT)) | (win_addr[1:0] != 2'b00);
  end

  // Requests are only looked at in IDLE; afterwards the latched copy drives
  // the memory, so requesters may change their inputs freely.
  // RDATA is cleared on writes and on errored accesses.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state    <= S_IDLE;
      prio     <= 1'b0;
      gnt      <= 1'b0;
      lat_we   <= 1'b0;
      lat_err  <= 1'b0;
      lat_addr <= '0;
      lat_wd   <= '0;
      rdata_q  <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (pick_valid) begin
            gnt      <= pick_gnt;
            prio     <= ~pick_gnt;
            lat_we   <= win_we;
            lat_err  <= win_err;
            lat_addr <= win_addr;
            lat_wd   <= win_wd;
            state    <= S_ACCESS;
          end
        end
        S_ACCESS: begin
          rdata_q <= (!lat_we && !lat_err) ? bus.MEM_RD : '0;
          state   <= S_RESP;
        end
        S_RESP: begin
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

  // Everything below is decoded from registers only. MEM_RW depends on the
  // state register, so an asynchronous reset during ACCESS kills the write
  // before the next clock edge.
  assign bus.ACK0     = (state == S_RESP) & ~gnt;
  assign bus.ACK1     = (state == S_RESP) &  gnt;
  assign bus.ERR      = (state == S_RESP) &  lat_err;
  assign bus.RDATA    = rdata_q;
  assign bus.BUSY     = (state == S_ACCESS) | (state == S_RESP);
  assign bus.MEM_ADDR = lat_addr;
  assign bus.MEM_RW   = (state == S_ACCESS) & lat_we & ~lat_err;
  assign bus.MEM_WD   = lat_wd;

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Two-port round-robin arbiter that shares the single-ported word data memory between two requesters (port 0: CPU load/store unit, port 1: debug/DMA loader). It serialises requests into one memory access at a time, drives the memory's address/RW/write-data inputs, captures read data, and returns a one-cycle acknowledge with status. It sits between the requesters and the data memory; the memory itself is unchanged (combinational read, write on rising CLK when RW=1 and ADDR < 1024).

## Interface
Parameters:
- ADDR_W, 32, address width (byte address)
- DATA_W, 32, data width
- MEM_LIMIT, 1024, first illegal byte address; accesses at or above it return error

Ports:
- CLK  in  1  system clock, rising edge
- RST  in  1  reset, asynchronous, active-high
- REQ0 / REQ1  in  1  request from port 0 / 1; held until ACKn
- WE0 / WE1  in  1  1 = write, 0 = read; stable while REQn high
- ADDR0 / ADDR1  in  ADDR_W  byte address; stable while REQn high
- WD0 / WD1  in  DATA_W  write data; stable while REQn high
- ACK0 / ACK1  out  1  one-cycle completion pulse
- ERR  out  1  status of the completing access, valid with ACKn
- RDATA  out  DATA_W  read data, valid with ACKn on a good read
- BUSY  out  1  high in ACCESS and RESP
- MEM_ADDR  out  ADDR_W  to memory ADDR
- MEM_RW  out  1  to memory RW (1 = write)
- MEM_WD  out  DATA_W  to memory WD
- MEM_RD  in  DATA_W  from memory RD

## Operation
- FSM: IDLE -> ACCESS -> RESP -> IDLE.
- IDLE: if REQ0 or REQ1, pick winner, latch WE/ADDR/WD of winner into lat_we/lat_addr/lat_wd, set gnt, go ACCESS; else stay.
- Pick: only one requesting -> that one; both -> port indicated by prio. After each grant, prio <= ~gnt (other port favoured).
- Error check at latch time: err_n = (ADDR >= MEM_LIMIT) | (ADDR[1:0] != 0).
- ACCESS: MEM_ADDR = lat_addr; MEM_RW = lat_we & ~err_n; MEM_WD = lat_wd. On the closing edge: memory performs write if MEM_RW; RDATA <= MEM_RD if read and no error, else RDATA <= 0. Go RESP.
- RESP: ACKgnt = 1, ERR = latched error, all other ACKs 0. Requests ignored. Go IDLE.
- Requester must drop REQ (or present a new request) by the edge ending RESP; a REQ still high in IDLE is a new request.
- Outside ACCESS: MEM_RW = 0, MEM_ADDR = lat_addr, MEM_WD = lat_wd (memory never written).
- Reset values: state IDLE, prio 0, gnt 0, lat_* 0, RDATA 0, ERR 0, ACK0/ACK1 0, BUSY 0, MEM_RW 0, MEM_ADDR 0, MEM_WD 0.
- Reset mid-operation: RST asserted in ACCESS forces MEM_RW low immediately (combinational from state), so no write occurs on the next edge; the in-flight request is dropped without ACK.
- Request changes while not in IDLE have no effect (latched copy used).

## Timing
- Request sampled at edge N in IDLE; memory access during cycle N..N+1; write/capture at edge N+1; ACK high N+1..N+2.
- Latency REQ-sampled to ACK: 1 cycle of ACCESS + ACK in next cycle; throughput one access per 3 cycles.
- Back-to-back contention: both REQ held -> grants alternate 0,1,0,1, one ACK every 3 cycles.
- All outputs registered or decoded from registered state only; no REQ->MEM_* combinational path.

## Structure
- Package dmem_arb_pkg: state enum (IDLE, ACCESS, RESP), port index constants PORT_CPU=0, PORT_DBG=1, default MEM_LIMIT.
- Sub-module dmem_rr_pick: combinational 2-way round-robin picker (req[1:0], prio -> valid, gnt); everything else in dmem_arbiter.

## Test plan
- Reset: RST high mid-run -> all outputs 0, state IDLE; RST in ACCESS of a write to 0x10 -> memory word 4 unchanged, no ACK.
- Single write/read: REQ0 write ADDR0=0x8 WD0=0xDEADBEEF -> ACK0 two cycles later, ERR=0; then read 0x8 -> RDATA=0xDEADBEEF with ACK0.
- Contention: REQ0 and REQ1 both reads held 4 accesses after reset -> ACK order 0,1,0,1, 3 cycles apart.
- Out of range: REQ1 write ADDR1=0x400 -> ACK1 with ERR=1, MEM_RW never 1, RDATA=0.
- Misaligned: REQ0 read ADDR0=0x6 -> ACK0, ERR=1, RDATA=0; next aligned read 0x4 -> ERR=0.
- Hold-through: requester keeps REQ1 high past ACK1 -> treated as new request; REQ0 arriving same cycle wins (prio).
